// File: rtl/fp32_mul_pkg.sv
// Shared constants, operand struct and helpers for the FP32 multiplier array.
`timescale 1ns/1ps
package fp32_mul_pkg;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned FLAG_UF  = 0;
  localparam int unsigned FLAG_OF  = 1;
  localparam int unsigned FLAG_INV = 2;
  localparam int unsigned EXP_W    = 10;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned PROD_W   = 48;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } operand_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_t;

  // Subnormals collapse to signed zero.
  function automatic operand_t unpack(input logic [31:0] x);
    operand_t o;
    o.sign    = x[31];
    o.exp     = x[30:23];
    o.mant    = x[22:0];
    o.is_zero = (x[30:23] == 8'h00);
    o.is_inf  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] == 23'h0);
    o.is_nan  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] != 23'h0);
    return o;
  endfunction

endpackage

// File: rtl/fp32_mul_lane.sv
// One FP32 multiplier lane: classify/multiply, normalise/round, special-case mux.
`timescale 1ns/1ps
module fp32_mul_lane
  import fp32_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic [2:0]  flags
);

  operand_t          op_a;
  operand_t          op_b;
  cls_t              cls_c;
  logic [PROD_W-1:0] prod_c;
  logic [EXP_W-1:0]  exp_sum_c;

  assign op_a      = unpack(a);
  assign op_b      = unpack(b);
  assign prod_c    = PROD_W'({1'b1, op_a.mant}) * PROD_W'({1'b1, op_b.mant});
  assign exp_sum_c = EXP_W'(op_a.exp) + EXP_W'(op_b.exp) - EXP_W'(BIAS);

  // Special-case priority: NaN/inf*0 first, then inf, then zero.
  always_comb begin
    cls_c = CLS_NORM;
    if (op_a.is_nan || op_b.is_nan ||
        (op_a.is_inf && op_b.is_zero) || (op_b.is_inf && op_a.is_zero))
      cls_c = CLS_NAN;
    else if (op_a.is_inf || op_b.is_inf)
      cls_c = CLS_INF;
    else if (op_a.is_zero || op_b.is_zero)
      cls_c = CLS_ZERO;
  end

  logic                    s1_sign;
  cls_t                    s1_cls;
  logic signed [EXP_W-1:0] s1_exp;
  logic [PROD_W-1:0]       s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_cls  <= CLS_NORM;
      s1_exp  <= '0;
      s1_prod <= '0;
    end else if (advance) begin
      s1_sign <= op_a.sign ^ op_b.sign;
      s1_cls  <= cls_c;
      s1_exp  <= $signed(exp_sum_c);
      s1_prod <= prod_c;
    end
  end

  logic [MANT_W-1:0]       mant_c;
  logic                    guard_c;
  logic                    sticky_c;
  logic                    round_c;
  logic [MANT_W:0]         mant_rnd_c;
  logic signed [EXP_W-1:0] exp_norm_c;
  logic signed [EXP_W-1:0] exp_rnd_c;

  // Normalise to 1.xxx, then round to nearest even on guard/sticky.
  always_comb begin
    mant_c     = s1_prod[45:23];
    guard_c    = s1_prod[22];
    sticky_c   = |s1_prod[21:0];
    exp_norm_c = s1_exp;
    if (s1_prod[47]) begin
      mant_c     = s1_prod[46:24];
      guard_c    = s1_prod[23];
      sticky_c   = |s1_prod[22:0];
      exp_norm_c = s1_exp + 10'sd1;
    end
    round_c    = guard_c & (sticky_c | mant_c[0]);
    mant_rnd_c = {1'b0, mant_c} + 24'(round_c);
    exp_rnd_c  = exp_norm_c + (mant_rnd_c[MANT_W] ? 10'sd1 : 10'sd0);
  end

  logic              s2_sign;
  cls_t              s2_cls;
  logic              s2_uf;
  logic              s2_of;
  logic [7:0]        s2_exp;
  logic [MANT_W-1:0] s2_mant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign <= 1'b0;
      s2_cls  <= CLS_NORM;
      s2_uf   <= 1'b0;
      s2_of   <= 1'b0;
      s2_exp  <= '0;
      s2_mant <= '0;
    end else if (advance) begin
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_uf   <= (exp_norm_c <= 10'sd0);
      s2_of   <= (exp_rnd_c >= $signed(EXP_W'(EXP_MAX)));
      s2_exp  <= exp_rnd_c[7:0];
      s2_mant <= mant_rnd_c[MANT_W-1:0];
    end
  end

  logic [31:0] res_c;
  logic [2:0]  flags_c;

  always_comb begin
    res_c   = {s2_sign, s2_exp, s2_mant};
    flags_c = '0;
    case (s2_cls)
      CLS_NAN: begin
        res_c             = QNAN;
        flags_c[FLAG_INV] = 1'b1;
      end
      CLS_INF:  res_c = {s2_sign, 8'(EXP_MAX), 23'h0};
      CLS_ZERO: res_c = {s2_sign, 31'h0};
      default: begin
        if (s2_uf) begin
          res_c            = {s2_sign, 31'h0};
          flags_c[FLAG_UF] = 1'b1;
        end else if (s2_of) begin
          res_c            = {s2_sign, 8'(EXP_MAX), 23'h0};
          flags_c[FLAG_OF] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      flags <= '0;
    end else if (advance) begin
      res   <= res_c;
      flags <= flags_c;
    end
  end

endmodule

// File: rtl/fp32_mul_array.sv
// LANES-wide FP32 multiplier with a shared 3-stage valid/ready pipeline and sideband.
`timescale 1ns/1ps
module fp32_mul_array
  import fp32_mul_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned FLAG_W = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_a,
  input  logic [LANES*32-1:0]   in_b,
  input  logic                  in_acc_sign,
  input  logic                  in_finish,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   out_res,
  output logic [LANES*FLAG_W-1:0] out_flags,
  output logic                  out_acc_sign,
  output logic                  out_finish,
  output logic                  busy,
  output logic                  frame_done
);

  logic advance;
  logic v1, v2;
  logic acc1, acc2;
  logic fin1, fin2;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = v1 | v2 | out_valid;

  // Valid and sideband chain; finish only travels with a real beat.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      out_valid    <= 1'b0;
      acc1         <= 1'b0;
      acc2         <= 1'b0;
      out_acc_sign <= 1'b0;
      fin1         <= 1'b0;
      fin2         <= 1'b0;
      out_finish   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_finish;
      if (advance) begin
        v1           <= in_valid;
        v2           <= v1;
        out_valid    <= v2;
        acc1         <= in_acc_sign;
        acc2         <= acc1;
        out_acc_sign <= acc2;
        fin1         <= in_valid && in_finish;
        fin2         <= fin1;
        out_finish   <= fin2;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp32_mul_lane u_lane (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .advance (advance),
      .a       (in_a[32*i +: 32]),
      .b       (in_b[32*i +: 32]),
      .res     (out_res[32*i +: 32]),
      .flags   (out_flags[FLAG_W*i +: FLAG_W])
    );
  end

endmodule

// File: tb/tb_fp32_mul_array.sv
// Bench for fp32_mul_array: directed vectors plus a scoreboard fed by an arithmetic FP32 model.
`timescale 1ns/1ps
module tb_fp32_mul_array;

  localparam int unsigned LANES = 8;
  localparam int unsigned W     = LANES * 32;
  localparam int unsigned FW    = LANES * 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_acc_sign;
  logic          in_finish;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [FW-1:0] out_flags;
  logic          out_acc_sign;
  logic          out_finish;
  logic          busy;
  logic          frame_done;

  always #5 sys_clk = ~sys_clk;

  fp32_mul_array #(.LANES(LANES), .FLAG_W(3)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_acc_sign  (in_acc_sign),
    .in_finish    (in_finish),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_flags    (out_flags),
    .out_acc_sign (out_acc_sign),
    .out_finish   (out_finish),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [FW-1:0] flags;
    logic          acc;
    logic          fin;
  } beat_t;

  beat_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int in_count = 0;
  int out_count = 0;
  int fd_count = 0;
  logic          fd_exp = 1'b0;
  logic          held = 1'b0;
  logic [W-1:0]  held_res;
  logic [FW-1:0] held_flags;
  logic          held_acc;
  logic          held_fin;

  logic [W-1:0] st_a[16];
  logic [W-1:0] st_b[16];
  logic [31:0]  da[16];
  logic [31:0]  db[16];
  logic [31:0]  dr[16];
  logic [2:0]   df[16];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Exact-integer FP32 product: {invalid, overflow, underflow, result}.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    bit an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC0_0000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz) return {3'b000, s, 31'h0};
    ma = 64'(a[22:0]) + 64'd8388608;
    mb = 64'(b[22:0]) + 64'd8388608;
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    if (e <= 0) return {3'b001, s, 31'h0};
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic acc, input logic fin);
    beat_t r;
    logic [34:0] t;
    for (int i = 0; i < LANES; i++) begin
      t = ref_mul(a[32*i +: 32], b[32*i +: 32]);
      r.res[32*i +: 32] = t[31:0];
      r.flags[3*i +: 3] = t[34:32];
    end
    r.acc = acc;
    r.fin = fin;
    return r;
  endfunction

  // Per-cycle compare against the scoreboard, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      sb_q.delete();
      fd_exp = 1'b0;
      held   = 1'b0;
    end else begin
      beat_t e;
      check("in_ready", W'(in_ready), W'(!out_valid || out_ready));
      check("frame_done", W'(frame_done), W'(fd_exp));
      if (frame_done) fd_count++;
      if (held) begin
        check("hold_res", out_res, held_res);
        check("hold_flags", W'(out_flags), W'(held_flags));
        check("hold_side", W'({out_acc_sign, out_finish}), W'({held_acc, held_fin}));
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (sb_q.size() == 0) begin
          check("extra_beat", W'(1), W'(0));
        end else begin
          e = sb_q.pop_front();
          check("res", out_res, e.res);
          check("flags", W'(out_flags), W'(e.flags));
          check("acc_sign", W'(out_acc_sign), W'(e.acc));
          check("finish", W'(out_finish), W'(e.fin));
        end
      end
      if (in_valid && in_ready) begin
        in_count++;
        sb_q.push_back(model(in_a, in_b, in_acc_sign, in_finish));
      end
      fd_exp     = out_valid && out_ready && out_finish;
      held       = out_valid && !out_ready;
      held_res   = out_res;
      held_flags = out_flags;
      held_acc   = out_acc_sign;
      held_fin   = out_finish;
    end
  end

  task automatic directed(input int base);
    for (int i = 0; i < LANES; i++) begin
      in_a[32*i +: 32] = da[base + i];
      in_b[32*i +: 32] = db[base + i];
    end
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_acc_sign = 1'b0;
    in_finish   = 1'b0;
    @(negedge sys_clk);
    check("dir_in_ready", W'(in_ready), W'(1));
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    @(posedge sys_clk); #1;
    check("lat_s2", W'(out_valid), W'(0));
    @(posedge sys_clk); #1;
    check("lat_s3", W'(out_valid), W'(1));
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("dir_res%0d", base + i), W'(out_res[32*i +: 32]), W'(dr[base + i]));
      check($sformatf("dir_flg%0d", base + i), W'(out_flags[3*i +: 3]), W'(df[base + i]));
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic stream(input int n, input bit toggle, input bit last_fin, input bit acc_all);
    int sent = 0;
    int cyc = 0;
    bit took;
    while (sent < n && cyc < 200) begin
      in_valid    = 1'b1;
      in_a        = st_a[sent];
      in_b        = st_b[sent];
      in_acc_sign = acc_all ? 1'b1 : 1'(sent % 2);
      in_finish   = last_fin && (sent == n - 1);
      out_ready   = toggle ? (cyc % 3 == 0) : 1'b1;
      @(negedge sys_clk);
      took = in_ready;
      @(posedge sys_clk); #1;
      if (took) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_finish = 1'b0;
    if (sent < n) check("stream_timeout", W'(sent), W'(n));
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || busy) && c < 100) begin
      @(posedge sys_clk); #1;
      c++;
    end
    if (c >= 100) check("drain_timeout", W'(sb_q.size()), W'(0));
  endtask

  task automatic fill_stream(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < LANES; i++) begin
        st_a[k][32*i +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        st_b[k][32*i +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      end
  endtask

  initial begin
    int fd_before;
    da = '{32'h40000000, 32'hBF800000, 32'h7F000000, 32'h7F800000,
           32'h00800000, 32'h80800000, 32'h3F800001, 32'h3FFFFFFF,
           32'h7FC00001, 32'hFF800000, 32'hFF800000, 32'h80000000,
           32'h00000001, 32'h3FC00000, 32'h3F800001, 32'h3F800003};
    db = '{32'h40400000, 32'h3F000000, 32'h7F000000, 32'h00000000,
           32'h3F000000, 32'h3F000000, 32'h3F800001, 32'h3FFFFFFF,
           32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h3F800000,
           32'hBF800000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
    dr = '{32'h40C00000, 32'hBF000000, 32'h7F800000, 32'h7FC00000,
           32'h00000000, 32'h80000000, 32'h3F800002, 32'h407FFFFE,
           32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h80000000,
           32'h80000000, 32'h40100000, 32'h3FC00002, 32'h3FC00004};
    df = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b001, 3'b000, 3'b000,
           3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    sys_rst_n   = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_acc_sign = 1'b0;
    in_finish   = 1'b0;
    out_ready   = 1'b1;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_res", out_res, W'(0));
    check("rst_out_flags", W'(out_flags), W'(0));
    check("rst_side", W'({out_acc_sign, out_finish, frame_done}), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_busy", W'(busy), W'(0));

    check("model_pin0", W'(ref_mul(32'h40000000, 32'h40400000)), W'(35'h0_40C00000));
    check("model_pin1", W'(ref_mul(32'h3FFFFFFF, 32'h3FFFFFFF)), W'(35'h0_407FFFFE));
    check("model_pin2", W'(ref_mul(32'h7F000000, 32'h7F000000)), W'({3'b010, 32'h7F800000}));
    check("model_pin3", W'(ref_mul(32'h3F800001, 32'h3FC00000)), W'(35'h0_3FC00002));

    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    directed(0);
    drain();
    directed(8);
    drain();

    fill_stream(10);
    stream(10, 1'b1, 1'b0, 1'b0);
    drain();
    check("beats_in_out", W'(out_count), W'(in_count));
    check("beats_total", W'(in_count), W'(12));

    fd_before = fd_count;
    fill_stream(4);
    stream(4, 1'b0, 1'b1, 1'b1);
    drain();
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    check("frame_pulses", W'(fd_count - fd_before), W'(1));
    check("beats_frame", W'(out_count), W'(in_count));

    fd_before = fd_count;
    fill_stream(3);
    stream(3, 1'b0, 1'b1, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_out_res", out_res, W'(0));
    check("arst_out_flags", W'(out_flags), W'(0));
    check("arst_side", W'({out_acc_sign, out_finish, frame_done}), W'(0));
    check("arst_busy", W'(busy), W'(0));
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (8) @(posedge sys_clk);
    #1;
    check("post_rst_busy", W'(busy), W'(0));
    check("post_rst_valid", W'(out_valid), W'(0));
    check("post_rst_frame", W'(fd_count - fd_before), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
